// File: rtl/dffram_seq_pkg.sv
// Shared types and lane-select constants for the byte-to-nibble DFFRAM sequencer.
package dffram_seq_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int BYTEWIDTH = 2 * NIBBLE_W;

    // Port A and port B use opposite lane polarities for the low nibble.
    localparam logic LOHI_WR_LO = 1'b1;
    localparam logic LOHI_WR_HI = 1'b0;
    localparam logic LOHI_RD_LO = 1'b0;
    localparam logic LOHI_RD_HI = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD_LO = 3'd3,
        RD_HI = 3'd4,
        RSP   = 3'd5
    } state_t;

endpackage

// File: rtl/dffram_byte_sequencer.sv
// Byte-wide request front-end for a 2R1W nibble DFFRAM: writes go out as two
// port-A nibble writes, reads gather two port-B nibbles into one response byte.
module dffram_byte_sequencer
    import dffram_seq_pkg::*;
#(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AWIDTH-1:0]     req_addr,
    input  logic [2*DWIDTH-1:0]   req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DWIDTH-1:0]   rsp_rdata,
    output logic                  busy,
    output logic [AWIDTH-1:0]     ram_addr_a,
    output logic [DWIDTH-1:0]     ram_wdata_a,
    output logic                  ram_lohi_a,
    output logic                  ram_w_en,
    output logic [AWIDTH-1:0]     ram_addr_b,
    output logic                  ram_lohi_b,
    input  logic [DWIDTH-1:0]     ram_rdata_b
);

    localparam int BW = 2 * DWIDTH;

    state_t              state;
    logic [AWIDTH-1:0]   addr_q;
    logic [DWIDTH-1:0]   wdata_hi_q;

    // The low nibble is launched straight from the request, so only the high one is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_hi_q  <= '0;
            ram_w_en    <= 1'b0;
            ram_lohi_a  <= 1'b0;
            ram_wdata_a <= '0;
            ram_lohi_b  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            ram_w_en    <= 1'b0;
            ram_lohi_a  <= 1'b0;
            ram_wdata_a <= '0;
            ram_lohi_b  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q     <= req_addr;
                        wdata_hi_q <= req_wdata[BW-1:DWIDTH];
                        if (req_write) begin
                            state       <= WR_LO;
                            ram_w_en    <= 1'b1;
                            ram_lohi_a  <= LOHI_WR_LO;
                            ram_wdata_a <= req_wdata[DWIDTH-1:0];
                        end else begin
                            state      <= RD_LO;
                            ram_lohi_b <= LOHI_RD_LO;
                        end
                    end
                end
                WR_LO: begin
                    state       <= WR_HI;
                    ram_w_en    <= 1'b1;
                    ram_lohi_a  <= LOHI_WR_HI;
                    ram_wdata_a <= wdata_hi_q;
                end
                WR_HI: begin
                    state <= IDLE;
                end
                RD_LO: begin
                    rsp_rdata[DWIDTH-1:0] <= ram_rdata_b;
                    ram_lohi_b            <= LOHI_RD_HI;
                    state                 <= RD_HI;
                end
                RD_HI: begin
                    rsp_rdata[BW-1:DWIDTH] <= ram_rdata_b;
                    rsp_valid              <= 1'b1;
                    state                  <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);
    assign ram_addr_a = addr_q;
    assign ram_addr_b = addr_q;

endmodule

// File: tb/tb_dffram_byte_sequencer.sv
// Bench for dffram_byte_sequencer with a behavioural nibble RAM and a byte-level reference memory.
module tb_dffram_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic [3:0] ram_addr_a;
    logic [3:0] ram_wdata_a;
    logic       ram_lohi_a;
    logic       ram_w_en;
    logic [3:0] ram_addr_b;
    logic       ram_lohi_b;
    logic [3:0] ram_rdata_b;

    int tests = 0;
    int fails = 0;

    logic [7:0] ram [16] = '{default: 8'h00};
    logic [7:0] ref_mem [16];

    always #5 clk = ~clk;

    dffram_byte_sequencer #(.AWIDTH(4), .DWIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy),
        .ram_addr_a(ram_addr_a), .ram_wdata_a(ram_wdata_a), .ram_lohi_a(ram_lohi_a),
        .ram_w_en(ram_w_en),
        .ram_addr_b(ram_addr_b), .ram_lohi_b(ram_lohi_b), .ram_rdata_b(ram_rdata_b)
    );

    // Nibble RAM: write lane 1 = low nibble, read lane 0 = low nibble.
    always @(posedge clk) begin
        if (ram_w_en) begin
            if (ram_lohi_a) ram[ram_addr_a][3:0] <= ram_wdata_a;
            else            ram[ram_addr_a][7:4] <= ram_wdata_a;
        end
    end
    assign ram_rdata_b = ram_lohi_b ? ram[ram_addr_b][7:4] : ram[ram_addr_b][3:0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL wr_ready_timeout req_ready=%0b want 1", req_ready);
        end
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0;
        step();
        step();
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [3:0] a, input int hold);
        int n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 8'h00;
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin step(); n++; end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[a]) begin
            fails++;
            $display("FAIL rd_data addr=%h valid=%0b got=%h want=%h", a, rsp_valid, rsp_rdata, ref_mem[a]);
        end
        for (int i = 0; i < hold; i++) begin
            step();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[a]) begin
                fails++;
                $display("FAIL rd_hold addr=%h valid=%0b got=%h want=%h", a, rsp_valid, rsp_rdata, ref_mem[a]);
            end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL rd_release valid=%0b ready=%0b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || ram_w_en !== 1'b0 ||
            rsp_rdata !== 8'h00 || busy !== 1'b0 || ram_addr_a !== 4'h0) begin
            fails++;
            $display("FAIL reset_state ready=%0b rvalid=%0b wen=%0b rdata=%h busy=%0b want all 0",
                     req_ready, rsp_valid, ram_w_en, rsp_rdata, busy);
        end
        step();
        rst = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release req_ready=%0b want 1", req_ready);
        end
        // Abort a write while its low nibble is on the bus.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h9; req_wdata = 8'h5A;
        step();
        req_valid = 1'b0;
        tests++;
        if (ram_w_en !== 1'b1) begin
            fails++;
            $display("FAIL reset_wrlo_entry ram_w_en=%0b want 1", ram_w_en);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (ram_w_en !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_write wen=%0b ready=%0b rvalid=%0b want 0/0/0",
                     ram_w_en, req_ready, rsp_valid);
        end
        step();
        rst = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1 || ram[9] !== ref_mem[9]) begin
            fails++;
            $display("FAIL reset_after_abort ready=%0b ram9=%h want 1/%h", req_ready, ram[9], ref_mem[9]);
        end
    endtask

    task automatic test_write();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h3; req_wdata = 8'hA5;
        step();
        req_valid = 1'b0;
        tests++;
        if (ram_w_en !== 1'b1 || ram_lohi_a !== 1'b1 || ram_wdata_a !== 4'h5 ||
            ram_addr_a !== 4'h3 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL write_lo wen=%0b lohi=%0b wd=%h addr=%h want 1/1/5/3",
                     ram_w_en, ram_lohi_a, ram_wdata_a, ram_addr_a);
        end
        step();
        tests++;
        if (ram_w_en !== 1'b1 || ram_lohi_a !== 1'b0 || ram_wdata_a !== 4'hA) begin
            fails++;
            $display("FAIL write_hi wen=%0b lohi=%0b wd=%h want 1/0/a", ram_w_en, ram_lohi_a, ram_wdata_a);
        end
        step();
        ref_mem[3] = 8'hA5;
        tests++;
        if (ram_w_en !== 1'b0 || ram_wdata_a !== 4'h0 || req_ready !== 1'b1 || ram[3] !== ref_mem[3]) begin
            fails++;
            $display("FAIL write_done wen=%0b wd=%h ready=%0b ram3=%h want 0/0/1/%h",
                     ram_w_en, ram_wdata_a, req_ready, ram[3], ref_mem[3]);
        end
    endtask

    task automatic test_readback();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h3;
        step();
        req_valid = 1'b0;
        tests++;
        if (ram_lohi_b !== 1'b0 || ram_addr_b !== 4'h3 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL read_lo lohi_b=%0b addr_b=%h rvalid=%0b want 0/3/0", ram_lohi_b, ram_addr_b, rsp_valid);
        end
        step();
        tests++;
        if (ram_lohi_b !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL read_hi lohi_b=%0b rvalid=%0b want 1/0", ram_lohi_b, rsp_valid);
        end
        step();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[3] || ram_lohi_b !== 1'b0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL read_rsp rvalid=%0b rdata=%h lohi_b=%0b want 1/%h/0",
                     rsp_valid, rsp_rdata, ram_lohi_b, ref_mem[3]);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_rdata !== ref_mem[3]) begin
            fails++;
            $display("FAIL read_accept rvalid=%0b busy=%0b rdata=%h want 0/0/%h", rsp_valid, busy, rsp_rdata, ref_mem[3]);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h3;
        step();
        req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[3] || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cyc=%0d rvalid=%0b rdata=%h ready=%0b want 1/%h/0",
                         i, rsp_valid, rsp_rdata, req_ready, ref_mem[3]);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release rvalid=%0b ready=%0b busy=%0b want 0/1/0", rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic       wr_t [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] ad_t [3] = '{4'h0, 4'hF, 4'hF};
        logic [7:0] wd_t [3] = '{8'h01, 8'h02, 8'h00};
        int acc [3] = '{0, 0, 0};
        int idx = 0;
        int cyc = 0;
        int n = 0;
        logic rdy;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = wr_t[0]; req_addr = ad_t[0]; req_wdata = wd_t[0];
        while (idx < 3 && cyc < 30) begin
            rdy = req_ready;
            step();
            cyc++;
            if (rdy) begin
                acc[idx] = cyc;
                if (wr_t[idx]) ref_mem[ad_t[idx]] = wd_t[idx];
                idx++;
                if (idx < 3) begin
                    req_write = wr_t[idx]; req_addr = ad_t[idx]; req_wdata = wd_t[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        tests++;
        if (idx != 3 || acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
            fails++;
            $display("FAIL b2b_spacing accepted=%0d gaps=%0d,%0d want 3 accepts gaps 3,3",
                     idx, acc[1] - acc[0], acc[2] - acc[1]);
        end
        while (!rsp_valid && n < 10) begin step(); n++; end
        tests++;
        if (rsp_valid !== 1'b1 || n != 2 || rsp_rdata !== ref_mem[15] || ram_addr_b !== 4'hF) begin
            fails++;
            $display("FAIL b2b_read rvalid=%0b lat=%0d rdata=%h addr_b=%h want 1/2/%h/f",
                     rsp_valid, n, rsp_rdata, ref_mem[15], ram_addr_b);
        end
        step();
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || ram[0] !== ref_mem[0] || ram[15] !== ref_mem[15]) begin
            fails++;
            $display("FAIL b2b_mem rvalid=%0b ram0=%h ramf=%h want 0/%h/%h",
                     rsp_valid, ram[0], ram[15], ref_mem[0], ref_mem[15]);
        end
    endtask

    task automatic test_torn_write();
        do_write(4'h7, 8'h00);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h7; req_wdata = 8'hC3;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        tests++;
        if (ram_w_en !== 1'b0) begin
            fails++;
            $display("FAIL torn_wen ram_w_en=%0b want 0", ram_w_en);
        end
        step();
        rst = 1'b0;
        #1;
        // Only the low nibble of C3 landed before the abort.
        ref_mem[7] = {ref_mem[7][7:4], 4'h3};
        tests++;
        if (ram[7] !== ref_mem[7]) begin
            fails++;
            $display("FAIL torn_ram ram7=%h want %h", ram[7], ref_mem[7]);
        end
        do_read(4'h7, 0);
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [7:0] d;
        for (int t = 0; t < 40; t++) begin
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, d);
            else do_read(a, int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (ram[i] !== ref_mem[i]) begin
                fails++;
                $display("FAIL final_mem addr=%0d got=%h want=%h", i, ram[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0;
        req_wdata = 8'h00; rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_readback();
        test_backpressure();
        test_back_to_back();
        test_torn_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
